// File: rtl/me_result_serializer.sv
// Serializes DATA_W-bit results as start/data(LSB first)/stop frames on one wire.
// Define ME_SER_PARITY_EN to insert an even-parity bit after the data bits.
module me_result_serializer #(
    parameter int unsigned DATA_W     = 20,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_valid,
    output logic              res_ready,
    output logic              serial20,
    output logic              busy,
    output logic [15:0]       frames_sent
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef ME_SER_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic                serial_q, serial_d;
    logic                busy_q, busy_d;
    logic [15:0]         frames_q, frames_d;
    logic                push, pop, bit_end;
`ifdef ME_SER_PARITY_EN
    logic                par_q, par_d;
`endif

    assign res_ready   = !init && !rst && (count_q < CNT_W'(FIFO_DEPTH));
    assign push        = res_valid && res_ready;
    assign pop         = (state_q == StIdle) && (count_q != '0);
    assign bit_end     = (cyc_q == CYC_W'(BIT_CYCLES - 1));
    assign serial20    = serial_q;
    assign busy        = busy_q;
    assign frames_sent = frames_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        cyc_d    = cyc_q;
        serial_d = serial_q;
        frames_d = frames_q;
`ifdef ME_SER_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != StIdle) begin
            cyc_d = bit_end ? '0 : cyc_q + CYC_W'(1);
        end
        case (state_q)
            StIdle: begin
                serial_d = 1'b1;
                if (pop) begin
                    state_d  = StStart;
                    shift_d  = mem_q[rd_ptr_q];
                    serial_d = 1'b0;
                    cyc_d    = '0;
`ifdef ME_SER_PARITY_EN
                    par_d    = ^mem_q[rd_ptr_q];
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d  = StData;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                    bit_d    = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef ME_SER_PARITY_EN
                        state_d  = StParity;
                        serial_d = par_q;
`else
                        state_d  = StStop;
                        serial_d = 1'b1;
`endif
                    end else begin
                        bit_d    = bit_q + BIT_W'(1);
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end
            end
`ifdef ME_SER_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d  = StStop;
                    serial_d = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d  = StIdle;
                    serial_d = 1'b1;
                    frames_d = frames_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        busy_d = (state_d != StIdle) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst || init) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            cyc_q    <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
`ifdef ME_SER_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q  <= count_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            cyc_q    <= cyc_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
`ifdef ME_SER_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // init aborts frames but keeps the completed-frame count
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q <= '0;
        end else if (!init) begin
            frames_q <= frames_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= res_data;
    end
endmodule

// File: tb/tb_me_result_serializer.sv
// Bench for me_result_serializer: two instances (BIT_CYCLES 1 and 3) checked every
// cycle against a frame-queue model, plus literal checks of the model itself.
module tb_me_result_serializer;
    localparam int DEPTH = 4;
`ifdef ME_SER_PARITY_EN
    localparam int FLEN = 23;
`else
    localparam int FLEN = 22;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1, init = 1'b0, res_valid = 1'b0;
    logic [19:0] res_data = '0;
    logic        ready [2];
    logic        ser [2];
    logic        bsy [2];
    logic [15:0] fs [2];

    always #5 clk = ~clk;

    me_result_serializer #(.DATA_W(20), .FIFO_DEPTH(DEPTH), .BIT_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .init(init), .res_data(res_data), .res_valid(res_valid),
        .res_ready(ready[0]), .serial20(ser[0]), .busy(bsy[0]), .frames_sent(fs[0]));
    me_result_serializer #(.DATA_W(20), .FIFO_DEPTH(DEPTH), .BIT_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .init(init), .res_data(res_data), .res_valid(res_valid),
        .res_ready(ready[1]), .serial20(ser[1]), .busy(bsy[1]), .frames_sent(fs[1]));

    // Model: accepted words wait in mq; a started frame is expanded into per-clock line values.
    logic [19:0] mq [2][$];
    bit          lq [2][$];
    bit          inf [2];
    bit          mser [2];
    logic [15:0] mfs [2];
    int          bcs [2] = '{1, 3};
    int          tests = 0, fails = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build(int k, logic [19:0] w);
        bit b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 20; i++) b.push_back(w[i]);
`ifdef ME_SER_PARITY_EN
        b.push_back(^w);
`endif
        b.push_back(1'b1);
        foreach (b[i]) repeat (bcs[k]) lq[k].push_back(b[i]);
    endtask

    task automatic model_edge(int k);
        bit push;
        push = res_valid && !rst && !init && (mq[k].size() < DEPTH);
        if (rst || init) begin
            mq[k].delete();
            lq[k].delete();
            inf[k]  = 1'b0;
            mser[k] = 1'b1;
            if (rst) mfs[k] = '0;
        end else begin
            if (lq[k].size() > 0) begin
                mser[k] = lq[k].pop_front();
                inf[k]  = 1'b1;
            end else if (inf[k]) begin
                mser[k] = 1'b1;
                inf[k]  = 1'b0;
                mfs[k]  = mfs[k] + 16'd1;
            end else if (mq[k].size() > 0) begin
                build(k, mq[k].pop_front());
                mser[k] = lq[k].pop_front();
                inf[k]  = 1'b1;
            end else begin
                mser[k] = 1'b1;
            end
            if (push) mq[k].push_back(res_data);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("serial20[%0d]", k), ser[k], mser[k]);
            chk($sformatf("busy[%0d]", k), bsy[k], inf[k] || (mq[k].size() > 0));
            chk($sformatf("frames_sent[%0d]", k), fs[k], mfs[k]);
            chk($sformatf("res_ready[%0d]", k), ready[k],
                !rst && !init && (mq[k].size() < DEPTH));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((inf[0] || inf[1] || mq[0].size() > 0 || mq[1].size() > 0) && n < 400) begin
            cyc();
            n++;
        end
        if (n >= 400) chk("idle_timeout", n, 0);
        cyc();
    endtask

    task automatic capture(int k, int n, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            cyc();
            v[i] = ser[k];
        end
    endtask

    initial begin
        logic [31:0] v, exp_v;
        logic [15:0] old;
        logic [19:0] w [6];
        int n, low, idx, stall;
        bit lowdone, a;

        for (int k = 0; k < 2; k++) begin
            mser[k] = 1'b1;
            mfs[k]  = '0;
            inf[k]  = 1'b0;
        end

        // Reset values
        repeat (3) cyc();
        chk("rst_serial", ser[0], 1);
        chk("rst_ready", ready[0], 0);
        chk("rst_busy", bsy[0], 0);
        chk("rst_frames", fs[0], 0);
        rst = 1'b0;
        cyc();

        // Single word 0xA5F3C
        res_data = 20'hA5F3C; res_valid = 1'b1;
        cyc();
        res_valid = 1'b0;
        capture(0, FLEN, v);
`ifdef ME_SER_PARITY_EN
        exp_v = 32'({1'b1, 1'b0, 20'hA5F3C, 1'b0});
`else
        exp_v = 32'({1'b1, 20'hA5F3C, 1'b0});
`endif
        chk("frame_a5f3c", v, exp_v);
        cyc();
        chk("a5f3c_frames", fs[0], 1);
        chk("a5f3c_busy_low", bsy[0], 0);
        wait_idle();

        // Single word 0x00001 (parity bit 1 when enabled)
        res_data = 20'h00001; res_valid = 1'b1;
        cyc();
        res_valid = 1'b0;
        capture(0, FLEN, v);
`ifdef ME_SER_PARITY_EN
        exp_v = 32'({1'b1, 1'b1, 20'h00001, 1'b0});
`else
        exp_v = 32'({1'b1, 20'h00001, 1'b0});
`endif
        chk("frame_00001", v, exp_v);
        wait_idle();

        // BIT_CYCLES=3 instance, 0xFFFFF
        res_data = 20'hFFFFF; res_valid = 1'b1;
        cyc();
        res_valid = 1'b0;
        old = fs[1]; n = 0; low = 0; lowdone = 1'b0;
        do begin
            cyc();
            n++;
            if (!lowdone) begin
                if (ser[1] == 1'b0) low++;
                else lowdone = 1'b1;
            end
        end while (fs[1] == old && n < 300);
        chk("bc3_start_low", low, 3);
        chk("bc3_frame_clocks", n - 1, FLEN * 3);
        wait_idle();

        // Burst of 6 words with valid held high
        for (int i = 0; i < 6; i++) w[i] = 20'($urandom);
        old = fs[0]; idx = 0; stall = -1; n = 0;
        res_valid = 1'b1; res_data = w[0];
        while (idx < 6 && n < 400) begin
            a = (mq[0].size() < DEPTH);
            cyc();
            n++;
            if (a) begin
                idx++;
                if (idx < 6) res_data = w[idx];
            end else if (stall < 0) begin
                stall = idx;
            end
        end
        res_valid = 1'b0;
        chk("burst_first_stall", stall, 5);
        wait_idle();
        chk("burst_frames", fs[0], old + 16'd6);

        // init mid-DATA with 2 words queued and a write presented
        res_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res_data = 20'($urandom);
            cyc();
        end
        res_valid = 1'b0;
        repeat (4) cyc();
        old = fs[0];
        init = 1'b1; res_valid = 1'b1; res_data = 20'h12345;
        #1;
        chk("init_ready", ready[0], 0);
        cyc();
        init = 1'b0; res_valid = 1'b0;
        chk("init_line", ser[0], 1);
        chk("init_busy", bsy[0], 0);
        chk("init_frames", fs[0], old);
        repeat (60) cyc();
        chk("init_no_more", fs[0], old);

        // Counter wrap
        force u0.frames_q = 16'hFFFF;
        #1;
        release u0.frames_q;
        mfs[0] = 16'hFFFF;
        res_data = 20'h0F0F0; res_valid = 1'b1;
        cyc();
        res_valid = 1'b0;
        wait_idle();
        chk("wrap", fs[0], 0);

        // Random traffic with occasional init/rst
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            init      = ($urandom_range(0, 199) == 0);
            res_valid = ($urandom_range(0, 2) != 0);
            res_data  = 20'($urandom);
            cyc();
        end
        rst = 1'b0; init = 1'b0; res_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
